// File: rtl/wisc_pkg.sv
// Shared WISC-S15 definitions: opcode encodings (also used by Control_Logic)
// and the instruction fetch FSM state type.
package wisc_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_NAND = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_XOR  = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_INC  = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_SRA  = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_SRL  = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_SLL  = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_LW   = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_SW   = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_LHB  = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_LLB  = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_B    = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_CALL = 4'b1101;
  localparam logic [OPC_W-1:0] OPC_RET  = 4'b1110;
  localparam logic [OPC_W-1:0] OPC_ERR  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FULL  = 3'd3,
    DRAIN = 3'd4,
    HALT  = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// WISC-S15 fetch front end: owns the PC, issues single-outstanding imem reads
// and holds one instruction for decode. Define WISC_FETCH_HALT_ON_ERR_EN to stop on ERR.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// REQ   | imem_rd_en asserted for address pc
// WAIT  | request outstanding, waiting for imem_rvalid
// FULL  | instruction held for decode until stall drops
// DRAIN | response owed to a redirected request, data discarded
// HALT  | ERR opcode held, fetch stopped until redirect
module instr_fetch_unit
  import wisc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

`ifdef WISC_FETCH_HALT_ON_ERR_EN
  assign fetch_err = (imem_rdata[INSTR_W-1 -: OPC_W] == OPC_ERR);
  assign halted    = (state == HALT);
`else
  assign fetch_err = 1'b0;
  assign halted    = 1'b0;
`endif

  assign imem_rd_en = (state == REQ);
  assign imem_addr  = pc;
  assign opcode     = instr[INSTR_W-1 -: OPC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Redirect wins everywhere; a redirected request still owes a response, hence DRAIN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = REQ;
      REQ:   state_next = redirect ? DRAIN : WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect)       state_next = REQ;
          else if (fetch_err) state_next = HALT;
          else                state_next = FULL;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      FULL:  if (redirect || !stall) state_next = REQ;
      DRAIN: if (imem_rvalid) state_next = REQ;
      HALT:  if (redirect) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= '0;
      pc_plus1    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
    end else if (state == WAIT && imem_rvalid) begin
      instr       <= imem_rdata;
      pc_plus1    <= pc + ADDR_W'(1);
      pc          <= pc + ADDR_W'(1);
      instr_valid <= 1'b1;
    end else if (state == FULL && !stall) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [15:0] pc_plus1;
  logic        instr_valid;
  logic        halted;

  int errors = 0;
  int checks = 0;

  int          mem_mode;
  logic [15:0] fixed_word;
  int          mem_lat;
  logic        rand_lat;
  int          resp_cnt;
  logic [15:0] resp_addr;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr(instr), .opcode(opcode), .pc_plus1(pc_plus1),
    .instr_valid(instr_valid), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (mem_mode)
      0:       return {a[3:0], 12'h000};
      1:       return {a[3:0] ^ a[7:4], a[11:0] ^ a[15:4]};
      default: return fixed_word;
    endcase
  endfunction

  // Memory responder: one response, latency cycles after each observed request.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    resp_cnt    = 0;
    resp_addr   = 16'h0000;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rst) begin
        resp_cnt = 0;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(resp_addr);
          end
        end
        if (imem_rd_en) begin
          resp_addr = imem_addr;
          resp_cnt  = rand_lat ? int'($urandom_range(4, 1)) : mem_lat;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    step();
    step();
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b want 0", imem_rd_en); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
    checks++; if (pc_plus1 !== 16'h0000) begin errors++; $display("FAIL reset_pc_plus1: got %h want 0000", pc_plus1); end
    rst = 1'b0;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_idle_rd_en: got %0b want 0", imem_rd_en); end
    step();
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %0b want 1", imem_rd_en); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_first_addr: got %h want 0000", imem_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_async: rd_en %0b want 0 before any edge", imem_rd_en); end
    step();
  endtask

  task automatic test_stream();
    mem_mode = 0; mem_lat = 1; rand_lat = 1'b0;
    do_reset();
    step();
    for (int n = 0; n < 4; n++) begin
      checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL stream_req%0d: rd_en %0b want 1", n, imem_rd_en); end
      checks++; if (imem_addr !== 16'(n)) begin errors++; $display("FAIL stream_addr%0d: got %h want %h", n, imem_addr, 16'(n)); end
      step();
      step();
      checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL stream_gap%0d: rd_en %0b want 0", n, imem_rd_en); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d: got %0b want 1", n, instr_valid); end
      checks++; if (opcode !== 4'(n)) begin errors++; $display("FAIL stream_opcode%0d: got %h want %h", n, opcode, 4'(n)); end
      checks++; if (pc_plus1 !== 16'(n + 1)) begin errors++; $display("FAIL stream_pc_plus1%0d: got %h want %h", n, pc_plus1, 16'(n + 1)); end
      step();
    end
  endtask

  task automatic test_stall();
    mem_mode = 2; fixed_word = 16'h8123; mem_lat = 1;
    do_reset();
    step();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %0b want 1", i, instr_valid); end
      checks++; if (instr !== 16'h8123) begin errors++; $display("FAIL stall_instr%0d: got %h want 8123", i, instr); end
      checks++; if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL stall_pc_plus1%0d: got %h want 0001", i, pc_plus1); end
      checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL stall_no_req%0d: rd_en %0b want 0", i, imem_rd_en); end
      if (i == 4) stall = 1'b0;
      step();
    end
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL stall_release_req: rd_en %0b want 1", imem_rd_en); end
    checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL stall_release_addr: got %h want 0001", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    logic got;
    mem_mode = 1; mem_lat = 4;
    do_reset();
    step();
    step();
    step();
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rdw_drain%0d: rd_en %0b valid %0b want 0 0", i, imem_rd_en, instr_valid); end
      step();
    end
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL rdw_req: rd_en %0b want 1", imem_rd_en); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL rdw_addr: got %h want 0040", imem_addr); end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (instr_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL rdw_timeout: instr_valid 0 want 1 within 12 cycles");
    end else begin
      checks++; if (instr !== 16'h4044) begin errors++; $display("FAIL rdw_instr: got %h want 4044", instr); end
      checks++; if (pc_plus1 !== 16'h0041) begin errors++; $display("FAIL rdw_pc_plus1: got %h want 0041", pc_plus1); end
    end
  endtask

  task automatic test_redirect_rvalid();
    mem_mode = 1; mem_lat = 2;
    do_reset();
    step();
    step();
    step();
    redirect = 1'b1; redirect_pc = 16'h1234;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdrv_valid: got %0b want 0", instr_valid); end
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL rdrv_req: rd_en %0b want 1", imem_rd_en); end
    checks++; if (imem_addr !== 16'h1234) begin errors++; $display("FAIL rdrv_addr: got %h want 1234", imem_addr); end
    step();
  endtask

  task automatic test_wrap();
    mem_mode = 0; mem_lat = 1;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_req: rd_en %0b addr %h want 1 ffff", imem_rd_en, imem_addr); end
    step();
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0b want 1", instr_valid); end
    checks++; if (instr !== 16'hF000) begin errors++; $display("FAIL wrap_instr: got %h want f000", instr); end
    checks++; if (pc_plus1 !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus1: got %h want 0000", pc_plus1); end
`ifdef WISC_FETCH_HALT_ON_ERR_EN
    redirect = 1'b1; redirect_pc = 16'h0000;
`endif
    step();
    redirect = 1'b0;
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next: rd_en %0b addr %h want 1 0000", imem_rd_en, imem_addr); end
  endtask

  task automatic test_err();
    mem_mode = 2; fixed_word = 16'hF000; mem_lat = 1;
    do_reset();
    step();
    step();
    step();
    checks++; if (instr_valid !== 1'b1 || opcode !== 4'hF) begin errors++; $display("FAIL err_fetch: valid %0b opcode %h want 1 f", instr_valid, opcode); end
`ifdef WISC_FETCH_HALT_ON_ERR_EN
    stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b1 || imem_rd_en !== 1'b0) begin
        errors++; $display("FAIL err_halt%0d: halted %0b valid %0b rd_en %0b want 1 1 0", i, halted, instr_valid, imem_rd_en);
      end
      step();
    end
    mem_mode = 1;
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL err_resume: halted %0b valid %0b want 0 0", halted, instr_valid); end
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0010) begin errors++; $display("FAIL err_resume_req: rd_en %0b addr %h want 1 0010", imem_rd_en, imem_addr); end
`else
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL err_no_halt: got %0b want 0", halted); end
    step();
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL err_flow: rd_en %0b addr %h want 1 0001", imem_rd_en, imem_addr); end
`endif
  endtask

  // Transaction model: tracks next fetch address, owed/stale response and the held instruction.
  task automatic test_random();
    logic [15:0] m_pc, m_instr, m_pp1, p_rpc, p_rdata;
    logic m_valid, m_halt, owed, stale, exp_rd;
    logic p_rd, p_redir, p_stall, p_rvalid;
    mem_mode = 1; rand_lat = 1'b1;
    do_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000; p_rpc = 16'h0000; p_rdata = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0; owed = 1'b0; stale = 1'b0;
    p_rd = 1'b0; p_redir = 1'b0; p_stall = 1'b0; p_rvalid = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (p_rd) owed = 1'b1;
      if (p_redir) begin
        m_pc = p_rpc; m_valid = 1'b0; m_halt = 1'b0;
        if (owed) begin
          if (p_rvalid) begin owed = 1'b0; stale = 1'b0; end
          else stale = 1'b1;
        end
      end else if (p_rvalid && owed) begin
        owed = 1'b0;
        if (stale) begin
          stale = 1'b0;
        end else begin
          m_valid = 1'b1; m_instr = p_rdata; m_pp1 = m_pc + 16'h0001; m_pc = m_pc + 16'h0001;
`ifdef WISC_FETCH_HALT_ON_ERR_EN
          m_halt = (p_rdata[15:12] == 4'hF);
`endif
        end
      end else if (m_valid && !p_stall && !m_halt) begin
        m_valid = 1'b0;
      end
      exp_rd = !owed && !m_valid;
      checks++; if (imem_rd_en !== exp_rd) begin errors++; $display("FAIL rnd_rd_en cyc %0d: got %0b want %0b", cyc, imem_rd_en, exp_rd); end
      checks++; if (instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d: got %0b want %0b", cyc, instr_valid, m_valid); end
      checks++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted cyc %0d: got %0b want %0b", cyc, halted, m_halt); end
      if (exp_rd) begin
        checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc %0d: got %h want %h", cyc, imem_addr, m_pc); end
      end
      if (m_valid) begin
        checks++; if (instr !== m_instr || opcode !== m_instr[15:12] || pc_plus1 !== m_pp1) begin
          errors++; $display("FAIL rnd_data cyc %0d: instr %h opcode %h pc_plus1 %h want %h %h %h",
                             cyc, instr, opcode, pc_plus1, m_instr, m_instr[15:12], m_pp1);
        end
      end
      p_rd = exp_rd;
      stall = ($urandom_range(2, 0) == 0);
      redirect = ($urandom_range(9, 0) == 0);
      redirect_pc = ($urandom_range(5, 0) == 0) ? 16'hFFFF : 16'($urandom);
      p_stall = stall; p_redir = redirect; p_rpc = redirect_pc;
      p_rvalid = imem_rvalid; p_rdata = imem_rdata;
    end
    redirect = 1'b0; stall = 1'b0; rand_lat = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_mode = 0; fixed_word = 16'h0000; mem_lat = 1; rand_lat = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
